// File: rtl/fetch_datapath.sv
// rtl/fetch_datapath.sv - PC/IR/ALUOut/MDR register block with fetch counter for a multicycle core
module fetch_datapath #(
    parameter int          DATA_WIDTH        = 16,
    parameter int          INSTRUCTION_WIDTH = 16,
    parameter int          WIDTH_OPCODE      = 4,
    parameter int          JUMP_WIDTH        = 12,
    parameter logic [15:0] RESET_VECTOR      = 16'h0000
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         PCWrite,
    input  logic                         PCWriteCond,
    input  logic [1:0]                   PCSource,
    input  logic                         IRWrite,
    input  logic                         MemRead,
    input  logic                         mem_select,
    input  logic                         alu_zero,
    input  logic [DATA_WIDTH-1:0]        alu_result,
    input  logic [DATA_WIDTH-1:0]        mem_rdata,
    output logic [DATA_WIDTH-1:0]        mem_addr,
    output logic [DATA_WIDTH-1:0]        pc,
    output logic [INSTRUCTION_WIDTH-1:0] instr,
    output logic [WIDTH_OPCODE-1:0]      opcode,
    output logic [DATA_WIDTH-1:0]        alu_out_q,
    output logic [DATA_WIDTH-1:0]        mdr,
    output logic [31:0]                  fetch_count
);

    localparam logic [DATA_WIDTH-1:0] RESET_PC = DATA_WIDTH'(RESET_VECTOR);

    logic [DATA_WIDTH-1:0]        pc_q, pc_d;
    logic [INSTRUCTION_WIDTH-1:0] ir_q, ir_d;
    logic [DATA_WIDTH-1:0]        aluout_q, aluout_d;
    logic [DATA_WIDTH-1:0]        mdr_q, mdr_d;
    logic [31:0]                  fetch_count_q, fetch_count_d;
    logic                         pc_we;
    logic [DATA_WIDTH-1:0]        jump_target;

    assign pc_we       = PCWrite | (PCWriteCond & alu_zero);
    // Jump keeps the upper PC region and replaces the low field from the current IR.
    assign jump_target = {pc_q[DATA_WIDTH-1:JUMP_WIDTH], ir_q[JUMP_WIDTH-1:0]};

    always_comb begin
        pc_d          = pc_q;
        ir_d          = ir_q;
        aluout_d      = alu_result;
        mdr_d         = mdr_q;
        fetch_count_d = fetch_count_q;
        if (pc_we) begin
            case (PCSource)
                2'd0:    pc_d = RESET_PC;
                2'd1:    pc_d = alu_result;
                2'd2:    pc_d = aluout_q;
                default: pc_d = jump_target;
            endcase
        end
        if (IRWrite) begin
            ir_d          = mem_rdata;
            fetch_count_d = fetch_count_q + 32'd1;
        end
        if (mem_select && MemRead) begin
            mdr_d = mem_rdata;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc_q          <= RESET_PC;
            ir_q          <= '0;
            aluout_q      <= '0;
            mdr_q         <= '0;
            fetch_count_q <= '0;
        end else begin
            pc_q          <= pc_d;
            ir_q          <= ir_d;
            aluout_q      <= aluout_d;
            mdr_q         <= mdr_d;
            fetch_count_q <= fetch_count_d;
        end
    end

    // Address mux sees registers only, so alu_result never reaches mem_addr in the same cycle.
    assign mem_addr    = mem_select ? aluout_q : pc_q;
    assign pc          = pc_q;
    assign instr       = ir_q;
    assign opcode      = ir_q[INSTRUCTION_WIDTH-1 -: WIDTH_OPCODE];
    assign alu_out_q   = aluout_q;
    assign mdr         = mdr_q;
    assign fetch_count = fetch_count_q;

endmodule

// File: tb/tb_fetch_datapath.sv
// tb/tb_fetch_datapath.sv - vector table, corner sequences and random reference-model check of fetch_datapath
module tb_fetch_datapath;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        PCWrite = 1'b0, PCWriteCond = 1'b0, IRWrite = 1'b0, MemRead = 1'b0;
    logic        mem_select = 1'b0, alu_zero = 1'b0;
    logic [1:0]  PCSource = 2'd0;
    logic [15:0] alu_result = 16'h0, mem_rdata = 16'h0;
    logic [15:0] mem_addr, pc, instr, alu_out_q, mdr;
    logic [3:0]  opcode;
    logic [31:0] fetch_count;

    int tests = 0;
    int fails = 0;

    fetch_datapath dut (
        .clk(clk), .reset(reset), .PCWrite(PCWrite), .PCWriteCond(PCWriteCond),
        .PCSource(PCSource), .IRWrite(IRWrite), .MemRead(MemRead), .mem_select(mem_select),
        .alu_zero(alu_zero), .alu_result(alu_result), .mem_rdata(mem_rdata),
        .mem_addr(mem_addr), .pc(pc), .instr(instr), .opcode(opcode),
        .alu_out_q(alu_out_q), .mdr(mdr), .fetch_count(fetch_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        pcw, pcwc;
        logic [1:0]  src;
        logic        irw, mrd, msel, zero;
        logic [15:0] alu, rdata;
        logic [15:0] e_pc, e_ir, e_alu, e_mdr;
        logic [31:0] e_fc;
    } vec_t;

    vec_t vecs[12];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic pcw, input logic pcwc, input logic [1:0] src, input logic irw,
                         input logic mrd, input logic msel, input logic zero,
                         input logic [15:0] alu, input logic [15:0] rdata);
        PCWrite = pcw; PCWriteCond = pcwc; PCSource = src; IRWrite = irw;
        MemRead = mrd; mem_select = msel; alu_zero = zero; alu_result = alu; mem_rdata = rdata;
    endtask

    task automatic edge_step();
        @(posedge clk);
        #1;
    endtask

    // Reference state, advanced from the architectural rules each cycle.
    logic [15:0] m_pc, m_ir, m_alu, m_mdr;
    logic [31:0] m_fc;

    initial begin
        vecs[0]  = '{1'b1,1'b0,2'd1,1'b0,1'b0,1'b0,1'b0,16'h0010,16'h0000,16'h0010,16'h0000,16'h0010,16'h0000,32'd0};
        vecs[1]  = '{1'b1,1'b0,2'd1,1'b1,1'b0,1'b0,1'b0,16'h0014,16'h3ABC,16'h0014,16'h3ABC,16'h0014,16'h0000,32'd1};
        vecs[2]  = '{1'b0,1'b0,2'd0,1'b0,1'b0,1'b0,1'b0,16'h0040,16'h0000,16'h0014,16'h3ABC,16'h0040,16'h0000,32'd1};
        vecs[3]  = '{1'b0,1'b1,2'd2,1'b0,1'b0,1'b0,1'b0,16'h0040,16'h0000,16'h0014,16'h3ABC,16'h0040,16'h0000,32'd1};
        vecs[4]  = '{1'b0,1'b1,2'd2,1'b0,1'b0,1'b0,1'b1,16'h0099,16'h0000,16'h0040,16'h3ABC,16'h0099,16'h0000,32'd1};
        vecs[5]  = '{1'b1,1'b1,2'd1,1'b0,1'b0,1'b0,1'b0,16'h5123,16'h0000,16'h5123,16'h3ABC,16'h5123,16'h0000,32'd1};
        vecs[6]  = '{1'b0,1'b0,2'd0,1'b1,1'b0,1'b0,1'b0,16'h0000,16'h7456,16'h5123,16'h7456,16'h0000,16'h0000,32'd2};
        vecs[7]  = '{1'b1,1'b0,2'd3,1'b0,1'b0,1'b0,1'b0,16'h0000,16'h0000,16'h5456,16'h7456,16'h0000,16'h0000,32'd2};
        vecs[8]  = '{1'b1,1'b0,2'd0,1'b0,1'b0,1'b0,1'b0,16'h0200,16'h0000,16'h0000,16'h7456,16'h0200,16'h0000,32'd2};
        vecs[9]  = '{1'b0,1'b0,2'd0,1'b0,1'b1,1'b1,1'b0,16'h0300,16'hBEEF,16'h0000,16'h7456,16'h0300,16'hBEEF,32'd2};
        vecs[10] = '{1'b0,1'b0,2'd0,1'b0,1'b0,1'b1,1'b0,16'h0300,16'h1111,16'h0000,16'h7456,16'h0300,16'hBEEF,32'd2};
        vecs[11] = '{1'b0,1'b0,2'd0,1'b0,1'b1,1'b0,1'b0,16'h0300,16'h2222,16'h0000,16'h7456,16'h0300,16'hBEEF,32'd2};

        // Async reset with no clock edge.
        #1 reset = 1'b1;
        #1;
        check("rst_pc", 32'(pc), 32'h0);
        check("rst_instr", 32'(instr), 32'h0);
        check("rst_opcode", 32'(opcode), 32'h0);
        check("rst_alu", 32'(alu_out_q), 32'h0);
        check("rst_mdr", 32'(mdr), 32'h0);
        check("rst_fc", fetch_count, 32'h0);
        check("rst_addr", 32'(mem_addr), 32'h0);
        @(negedge clk);
        reset = 1'b0;

        begin
            logic [15:0] prev_pc, prev_alu;
            prev_pc = 16'h0; prev_alu = 16'h0;
            for (int i = 0; i < 12; i++) begin
                drive(vecs[i].pcw, vecs[i].pcwc, vecs[i].src, vecs[i].irw, vecs[i].mrd,
                      vecs[i].msel, vecs[i].zero, vecs[i].alu, vecs[i].rdata);
                #1;
                check($sformatf("v%0d_addr_pre", i), 32'(mem_addr), 32'(vecs[i].msel ? prev_alu : prev_pc));
                edge_step();
                check($sformatf("v%0d_pc", i), 32'(pc), 32'(vecs[i].e_pc));
                check($sformatf("v%0d_instr", i), 32'(instr), 32'(vecs[i].e_ir));
                check($sformatf("v%0d_opcode", i), 32'(opcode), 32'(vecs[i].e_ir[15:12]));
                check($sformatf("v%0d_alu", i), 32'(alu_out_q), 32'(vecs[i].e_alu));
                check($sformatf("v%0d_mdr", i), 32'(mdr), 32'(vecs[i].e_mdr));
                check($sformatf("v%0d_fc", i), fetch_count, vecs[i].e_fc);
                check($sformatf("v%0d_addr_post", i), 32'(mem_addr),
                      32'(vecs[i].msel ? vecs[i].e_alu : vecs[i].e_pc));
                prev_pc = vecs[i].e_pc; prev_alu = vecs[i].e_alu;
                @(negedge clk);
            end
        end

        // Counter wrap: preload the counter, then one IR load.
        drive(1'b0,1'b0,2'd0,1'b0,1'b0,1'b0,1'b0,16'h0,16'h0);
        dut.fetch_count_q = 32'hFFFF_FFFF;
        #1;
        check("wrap_preload", fetch_count, 32'hFFFF_FFFF);
        @(negedge clk);
        drive(1'b0,1'b0,2'd0,1'b1,1'b0,1'b0,1'b0,16'h0,16'hC001);
        edge_step();
        check("wrap_fc", fetch_count, 32'h0);
        check("wrap_instr", 32'(instr), 32'hC001);

        // Randomized run against the rule-level model.
        @(negedge clk);
        m_pc = pc; m_ir = instr; m_alu = alu_out_q; m_mdr = mdr; m_fc = fetch_count;
        for (int n = 0; n < 400; n++) begin
            logic [15:0] n_pc;
            drive(1'($urandom), 1'($urandom), 2'($urandom), 1'($urandom), 1'($urandom),
                  1'($urandom), 1'($urandom), 16'($urandom), 16'($urandom));
            #1;
            check("rnd_addr_pre", 32'(mem_addr), 32'(mem_select ? m_alu : m_pc));
            n_pc = m_pc;
            if (PCWrite || (PCWriteCond && alu_zero)) begin
                if (PCSource == 2'd0) n_pc = 16'h0000;
                else if (PCSource == 2'd1) n_pc = alu_result;
                else if (PCSource == 2'd2) n_pc = m_alu;
                else n_pc = (m_pc & 16'hF000) | (m_ir & 16'h0FFF);
            end
            if (mem_select && MemRead) m_mdr = mem_rdata;
            if (IRWrite) begin
                m_ir = mem_rdata;
                m_fc = m_fc + 1;
            end
            m_alu = alu_result;
            m_pc  = n_pc;
            edge_step();
            check("rnd_pc", 32'(pc), 32'(m_pc));
            check("rnd_instr", 32'(instr), 32'(m_ir));
            check("rnd_opcode", 32'(opcode), 32'(m_ir >> 12));
            check("rnd_alu", 32'(alu_out_q), 32'(m_alu));
            check("rnd_mdr", 32'(mdr), 32'(m_mdr));
            check("rnd_fc", fetch_count, m_fc);
            @(negedge clk);
        end

        // Reset asserted mid-instruction, then a normal fetch edge.
        drive(1'b1,1'b0,2'd1,1'b1,1'b1,1'b1,1'b0,16'hAAAA,16'h5555);
        @(posedge clk);
        #2 reset = 1'b1;
        #1;
        check("mid_rst_pc", 32'(pc), 32'h0);
        check("mid_rst_instr", 32'(instr), 32'h0);
        check("mid_rst_alu", 32'(alu_out_q), 32'h0);
        check("mid_rst_mdr", 32'(mdr), 32'h0);
        check("mid_rst_fc", fetch_count, 32'h0);
        @(negedge clk);
        reset = 1'b0;
        drive(1'b1,1'b0,2'd1,1'b1,1'b0,1'b0,1'b0,16'h0002,16'h1234);
        edge_step();
        check("post_rst_pc", 32'(pc), 32'h0002);
        check("post_rst_instr", 32'(instr), 32'h1234);
        check("post_rst_opcode", 32'(opcode), 32'h1);
        check("post_rst_fc", fetch_count, 32'd1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/fetch_datapath.md
# fetch_datapath

Architectural register block between the multicycle control FSM and memory/ALU. It holds the program counter (PC), instruction register (IR), ALU output buffer (ALUOut) and memory data register (MDR), applying the FSM's enables each cycle. It drives the memory address mux from `mem_select` and returns `opcode` to the FSM. It also keeps a 32-bit fetch counter for debug and performance visibility.

## Interface
- `DATA_WIDTH`, 16: width of PC, ALUOut, MDR, memory address/data.
- `INSTRUCTION_WIDTH`, 16: width of IR; must equal `DATA_WIDTH`.
- `WIDTH_OPCODE`, 4: opcode field width, taken from IR MSBs.
- `JUMP_WIDTH`, 12: low IR bits used as the jump target field.
- `RESET_VECTOR`, 16'h0000: PC value on reset and on `PCSource`=0.

Ports:
- `clk`  in  1  single clock; all state updates on the rising edge.
- `reset`  in  1  asynchronous, active-high; clears all state immediately.
- `PCWrite`  in  1  unconditional PC write enable.
- `PCWriteCond`  in  1  conditional PC write enable, qualified by `alu_zero`.
- `PCSource`  in  2  PC source select: 0=RESET_VECTOR, 1=`alu_result`, 2=ALUOut register, 3=jump.
- `IRWrite`  in  1  IR load enable.
- `MemRead`  in  1  memory read strobe, passed through and used to qualify MDR load.
- `mem_select`  in  1  address select: 0=PC, 1=ALUOut register.
- `alu_zero`  in  1  ALU zero flag, same cycle.
- `alu_result`  in  DATA_WIDTH  combinational ALU output.
- `mem_rdata`  in  DATA_WIDTH  memory read data, combinational from `mem_addr`.
- `mem_addr`  out  DATA_WIDTH  memory address.
- `pc`  out  DATA_WIDTH  current PC.
- `instr`  out  INSTRUCTION_WIDTH  current IR.
- `opcode`  out  WIDTH_OPCODE  `instr[INSTRUCTION_WIDTH-1 -: WIDTH_OPCODE]`, fed to the control FSM.
- `alu_out_q`  out  DATA_WIDTH  ALUOut register.
- `mdr`  out  DATA_WIDTH  memory data register, feeding the MemToReg mux.
- `fetch_count`  out  32  number of IR loads since reset.

## Operation
- Reset values while `reset` is high: `pc`=RESET_VECTOR, `instr`=0, `opcode`=0 (NOP), `alu_out_q`=0, `mdr`=0, `fetch_count`=0, `mem_addr`=RESET_VECTOR.
- PC write enable: `pc_we = PCWrite | (PCWriteCond & alu_zero)`.
- When `pc_we` is asserted, PC loads from the source selected by `PCSource`.
  - Jump target = `{pc[DATA_WIDTH-1:JUMP_WIDTH], instr[JUMP_WIDTH-1:0]}`, built from the current (pre-edge) PC and IR.
- ALUOut register loads `alu_result` on every clock edge, with no enable.
- IR loads `mem_rdata` when `IRWrite`=1; otherwise it holds.
- MDR loads `mem_rdata` when `mem_select & MemRead`; otherwise it holds.
- `fetch_count` increments by 1 on every edge with `IRWrite`=1. It wraps from 32'hFFFFFFFF to 0.
- `mem_addr` is combinational from registers only: `mem_select ? alu_out_q : pc`. There is no combinational path from `alu_result` to `mem_addr`.
- All arithmetic is modulo 2^DATA_WIDTH. PC increment is computed by the ALU; this block does no addition except in `fetch_count`.

## Timing
- Every register has 1-cycle latency: an enable sampled at edge N shows its effect on outputs after edge N.
- Simultaneous `IRWrite` and `PCWrite` (fetch cycle):
  - IR captures the instruction at the old PC.
  - PC takes the new value at the same edge.
  - `opcode` is valid to the FSM in the following (decode) cycle.
- Simultaneous `PCWrite` and `PCWriteCond`: `pc_we`=1 regardless of `alu_zero`.
- `PCSource`=2 uses ALUOut as captured at the previous edge. This makes a branch target computed in decode usable in the branch-complete cycle while the ALU performs the compare.
- Reset asserted mid-instruction: all registers clear asynchronously. The first edge after deassertion is a normal edge driven by the FSM's reset-state outputs.
- `mem_select` may change every cycle. `mem_addr` follows within the same cycle, glitch-free at register boundaries.

## Test plan
- Reset: drive random state, pulse `reset` between edges → all outputs are 0 and `pc`=0 immediately, with no clock edge needed.
- Fetch: `pc`=0x0010, `mem_rdata`=0x3ABC, `IRWrite`=1, `PCWrite`=1, `PCSource`=1, `alu_result`=0x0014 → after the edge: `instr`=0x3ABC, `opcode`=3, `pc`=0x0014, `fetch_count`=1.
- Conditional branch:
  - ALUOut=0x0040, `PCWriteCond`=1, `PCSource`=2, `alu_zero`=1 → `pc`=0x0040.
  - Repeat with `alu_zero`=0 → `pc` unchanged.
- Jump: `pc`=0x5123, `instr`=0x7456, `PCWrite`=1, `PCSource`=3 → `pc`=0x5456.
- Load: `alu_result`=0x0200 at edge N; at edge N+1 `mem_select`=1, `MemRead`=1 → `mem_addr`=0x0200 between the two edges, `mdr`=`mem_rdata` after N+1. With `MemRead`=0, `mdr` holds.
- Counter wrap: preload via 2^32 IR loads (or force `fetch_count`) to 0xFFFFFFFF, then one `IRWrite` → `fetch_count`=0.
